fetch_queue: RTL and testbench

//  Decoupling instruction queue between the fetch unit (IFU) and decode/control.

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue_mem.sv | 27 ++
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and the stored entry layout for the fetch-to-decode queue.
package fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int ENTRY_W = 32 + INSTR_W;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port, one asynchronous read port.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_ptr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [PTR_W-1:0]   rd_ptr,
    output logic [ENTRY_W-1:0] rd_data
);

    // No reset on the array: occupancy lives in the pointers, stale data is never shown.
    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode: in-order {pc, instr} pairs with pc+4,
// single-cycle flush for redirects.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pcplus4,
    output logic [PTR_W:0]     count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    fq_entry_t        wr_entry;
    fq_entry_t        head;

    // Ready depends only on occupancy (and reset), never on the decode side.
    assign in_ready  = reset && (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_entry.pc    = in_pc;
    assign wr_entry.instr = in_instr;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push && !flush),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_entry),
        .rd_ptr  (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // An empty queue presents a zero PC and a NOP so decode never sees stale storage.
    assign out_pc      = out_valid ? head.pc : 32'h0;
    assign out_instr   = out_valid ? head.instr : NOP_INSTR;
    assign out_pcplus4 = out_valid ? (head.pc + PC_STEP) : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pcplus4;
    logic [2:0]  count;

    int compared;
    int mismatched;

    fetch_queue #(
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_pcplus4 (out_pcplus4),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction words are derived from the PC so ordering errors show up in both fields.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic ordy,
                                 input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = pc ^ 32'h5a5a_0000;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0);

        // Reset held low with fetch asserting valid
        tick();
        tick();
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_count", {29'b0, count}, 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_out_pcplus4", out_pcplus4, 32'h0);

        // Fill with 0x3000..0x300C while decode stalls
        reset = 1'b1;
        #1;
        checkOutput("rel_in_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b0);
        tick();
        checkOutput("lat_out_pc", out_pc, 32'h0000_3000);
        checkOutput("lat_out_instr", out_instr, 32'h5a5a_3000);
        checkOutput("lat_count", {29'b0, count}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0000_3000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("full_count", {29'b0, count}, 32'd4);
        checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("full_out_pc", out_pc, 32'h0000_3000);
        checkOutput("full_pcplus4", out_pcplus4, 32'h0000_3004);
        applyStimulus(1'b1, 32'h0000_3010, 1'b0, 1'b0);
        tick();
        checkOutput("ovf_count", {29'b0, count}, 32'd4);
        checkOutput("ovf_out_pc", out_pc, 32'h0000_3000);

        // Drain while streaming 0x3010..0x301C; first cycle is pop-only since full
        applyStimulus(1'b1, 32'h0000_3010, 1'b1, 1'b0);
        tick();
        checkOutput("drain1_pc", out_pc, 32'h0000_3004);
        checkOutput("drain1_count", {29'b0, count}, 32'd3);
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(1'b1, 32'h0000_3010 + 32'(4 * (i - 2)), 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("stream%0d_pc", i), out_pc, 32'h0000_3000 + 32'(4 * i));
            checkOutput($sformatf("stream%0d_count", i), {29'b0, count}, 32'd3);
        end
        checkOutput("wrap_instr", out_instr, 32'h5a5a_3014);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("tail1_pc", out_pc, 32'h0000_3018);
        tick();
        checkOutput("tail2_pc", out_pc, 32'h0000_301c);
        checkOutput("tail2_count", {29'b0, count}, 32'd1);
        tick();
        checkOutput("empty_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("empty_count", {29'b0, count}, 32'd0);

        // Flush at count=3 with concurrent push and pop
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0000_5000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("preflush_count", {29'b0, count}, 32'd3);
        applyStimulus(1'b1, 32'h0000_6000, 1'b1, 1'b1);
        #1;
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("flush_count", {29'b0, count}, 32'd0);
        checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_out_pc", out_pc, 32'h0);
        applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0);
        tick();
        checkOutput("postflush_pc", out_pc, 32'h0000_4000);
        checkOutput("postflush_count", {29'b0, count}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("postflush_drain", {29'b0, count}, 32'd0);

        // Asynchronous reset between clock edges with two entries queued
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h0000_7000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("prerst_count", {29'b0, count}, 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("arst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("arst_count", {29'b0, count}, 32'd0);
        checkOutput("arst_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("arst_out_pc", out_pc, 32'h0);
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 32'h0000_7100, 1'b0, 1'b0);
        #1;
        checkOutput("arel_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("arel_out_pc", out_pc, 32'h0000_7100);
        checkOutput("arel_count", {29'b0, count}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("arel_drain", {29'b0, count}, 32'd0);

        // PC wrap on pcplus4, and push with pop requested while empty
        applyStimulus(1'b1, 32'hffff_fffc, 1'b1, 1'b0);
        tick();
        checkOutput("edge_count", {29'b0, count}, 32'd1);
        checkOutput("edge_out_pc", out_pc, 32'hffff_fffc);
        checkOutput("edge_pcplus4", out_pcplus4, 32'h0000_0000);
        checkOutput("edge_instr", out_instr, 32'ha5a5_fffc);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("edge_drain", {29'b0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
